period_gen: RTL

PERIOD_GEN -- requirements
Module: period_gen

---
 rtl/period_gen_pkg.sv | 13 +
 rtl/period_gen.sv | 131 +++++++++++++
 2 files changed

// File: rtl/period_gen_pkg.sv
// Shared types and defaults for the programmable square-wave generator.
package period_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    localparam int DEF_CLK_FREQ = 125_000_000;
    localparam int DEF_NS_SHIFT = 3;

endpackage

// File: rtl/period_gen.sv
// Square-wave generator: period/high times in ns, converted to clock ticks,
// double-buffered so a new configuration only takes effect at a period boundary.
module period_gen
    import period_gen_pkg::*;
#(
    parameter int CLK_FREQ = DEF_CLK_FREQ,
    parameter int NS_SHIFT = DEF_NS_SHIFT,
    parameter int WIDTH    = 32
) (
    input  logic             sysclk,
    input  logic             resetn,
    input  logic             enable,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_period_ns,
    input  logic [WIDTH-1:0] cfg_high_ns,
    output logic             wave_o,
    output logic             edge_o,
    output logic             cfg_err
);

    // The ns-to-tick shift only makes sense if it matches the clock period.
    if ((1_000_000_000 / CLK_FREQ) != (1 << NS_SHIFT)) begin : g_tick_check
        $error("period_gen: NS_SHIFT does not match CLK_FREQ");
    end

    state_t           state, state_nxt;
    logic [WIDTH-1:0] cnt, cnt_nxt;

    logic [WIDTH-1:0] act_p, act_h;
    logic             act_valid;
    logic [WIDTH-1:0] pend_p, pend_h;
    logic             pend_valid;

    logic [WIDTH-1:0] conv_p, conv_h;
    logic             xfer, cfg_bad, apply;
    logic [WIDTH-1:0] eff_p, eff_h;
    logic             eff_valid;

    assign conv_p    = cfg_period_ns >> NS_SHIFT;
    assign conv_h    = cfg_high_ns >> NS_SHIFT;
    assign cfg_bad   = (conv_p < WIDTH'(2)) || (conv_h == '0) || (conv_h >= conv_p);
    assign cfg_ready = !pend_valid;
    assign xfer      = cfg_valid && cfg_ready;

    // NOTE: every variable gets a default before the case so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        apply     = 1'b0;
        eff_p     = pend_valid ? pend_p : act_p;
        eff_h     = pend_valid ? pend_h : act_h;
        eff_valid = pend_valid || act_valid;
        unique case (state)
            IDLE: begin
                apply = pend_valid;
                if (enable && eff_valid) begin
                    state_nxt = HIGH;
                    cnt_nxt   = eff_h - WIDTH'(1);
                end
            end
            HIGH: begin
                if (cnt == '0) begin
                    state_nxt = LOW;
                    cnt_nxt   = act_p - act_h - WIDTH'(1);
                end else begin
                    cnt_nxt = cnt - WIDTH'(1);
                end
            end
            LOW: begin
                if (cnt == '0) begin
                    if (enable) begin
                        state_nxt = HIGH;
                        apply     = pend_valid;
                        cnt_nxt   = eff_h - WIDTH'(1);
                    end else begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end
                end else begin
                    cnt_nxt = cnt - WIDTH'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Period length eff_p is implied by the LOW reload; only H is needed on entry.
    logic unused_eff_p;
    assign unused_eff_p = ^eff_p;

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge sysclk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            cnt        <= '0;
            wave_o     <= 1'b0;
            edge_o     <= 1'b0;
            cfg_err    <= 1'b0;
            act_p      <= '0;
            act_h      <= '0;
            act_valid  <= 1'b0;
            pend_p     <= '0;
            pend_h     <= '0;
            pend_valid <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            wave_o  <= (state_nxt == HIGH);
            edge_o  <= (state_nxt == HIGH) && (state != HIGH);
            cfg_err <= xfer && cfg_bad;
            if (apply) begin
                act_p     <= pend_p;
                act_h     <= pend_h;
                act_valid <= 1'b1;
            end
            // xfer needs an empty pending slot and apply needs a full one, so they never collide.
            if (xfer && !cfg_bad) begin
                pend_p     <= conv_p;
                pend_h     <= conv_h;
                pend_valid <= 1'b1;
            end else if (apply) begin
                pend_valid <= 1'b0;
            end
        end
    end

endmodule
